// File: rtl/nes_wram_mirrored_if.sv
// CPU-side bus of the NES work-RAM model: address, direction and M2 phase.
// The data bus stays a plain inout port on the RAM so tristate resolution happens at the net.
interface nes_wram_mirrored_if;
  logic        M2;
  logic        RnW;
  logic [15:0] Addr;

  modport master (output M2, output RnW, output Addr);
  modport slave  (input  M2, input  RnW, input  Addr);
endinterface

// File: rtl/nes_wram_mirrored.sv
// NES work-RAM with a mirrored decode window, M2-falling-edge write commit and
// an optional post-reset clear sequencer that fills the array before Ready.
module nes_wram_mirrored #(
  parameter int         AW             = 11,
  parameter int         WIN_BITS       = 13,
  parameter logic [15:0] BASE          = 16'h0000,
  parameter bit         CLEAR_ON_RESET = 1'b1,
  parameter logic [7:0] FILL           = 8'h00
) (
  input  logic                 CLK,
  input  logic                 n_RES,
  nes_wram_mirrored_if.slave   bus,
  inout  wire  [7:0]           Data,
  output logic                 Ready,
  output logic [15:0]          WrCount
);

  localparam int DEPTH = 1 << AW;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  localparam state_t RST_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_READY;

  state_t          state_reg, state_next;
  logic [AW-1:0]   cnt_reg, cnt_next;
  logic            clear_we;

  logic            m2_reg;
  logic [AW-1:0]   a_lat_reg;
  logic [7:0]      d_lat_reg;
  logic            w_lat_reg;
  logic [15:0]     wr_count_reg;

  logic [7:0]      mem [DEPTH];

  logic            sel;
  logic [AW-1:0]   idx;
  logic            ready;
  logic            commit;
  logic            unused_addr;

  // Only the low AW bits index the array, so every window slot aliases the same cells.
  assign idx         = bus.Addr[AW-1:0];
  assign unused_addr = ^bus.Addr;

  generate
    if (WIN_BITS >= 16) begin : g_sel_all
      assign sel = 1'b1;
    end else begin : g_sel_cmp
      assign sel = (bus.Addr[15:WIN_BITS] == BASE[15:WIN_BITS]);
    end
  endgenerate

  assign ready  = (state_reg == ST_READY);
  assign commit = m2_reg & ~bus.M2 & w_lat_reg & ready;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    clear_we   = 1'b0;
    case (state_reg)
      ST_CLEAR: begin
        clear_we = 1'b1;
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == {AW{1'b1}}) begin
          state_next = ST_READY;
        end
      end
      ST_READY: begin
        state_next = ST_READY;
      end
      default: begin
        state_next = ST_READY;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge n_RES) begin
    if (!n_RES) begin
      state_reg    <= RST_STATE;
      cnt_reg      <= '0;
      m2_reg       <= 1'b0;
      a_lat_reg    <= '0;
      d_lat_reg    <= '0;
      w_lat_reg    <= 1'b0;
      wr_count_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      m2_reg    <= bus.M2;
      // The last M2-high sample carries the address and data of the cycle.
      if (bus.M2) begin
        a_lat_reg <= idx;
        d_lat_reg <= Data;
        w_lat_reg <= sel & ~bus.RnW;
      end
      if (commit && (wr_count_reg != 16'hFFFF)) begin
        wr_count_reg <= wr_count_reg + 1'b1;
      end
    end
  end

  // Clear and CPU commit are mutually exclusive: one needs CLEAR, the other READY.
  always_ff @(posedge CLK) begin
    if (clear_we) begin
      mem[cnt_reg] <= FILL;
    end else if (commit) begin
      mem[a_lat_reg] <= d_lat_reg;
    end
  end

  assign Data    = (sel & bus.RnW & bus.M2 & ready) ? mem[idx] : 8'bz;
  assign Ready   = ready;
  assign WrCount = wr_count_reg;

endmodule

// File: tb/tb_nes_wram_mirrored.sv
// Self-checking bench: four RAM instances with disjoint windows share one bus,
// checked every cycle against a transaction-level model of storage, Ready and WrCount.
module tb_nes_wram_mirrored;

  localparam int NI = 4;

  logic CLK = 1'b0;
  logic n_RES;
  always #5 CLK = ~CLK;

  nes_wram_mirrored_if bus ();
  wire  [7:0] Data;
  logic [7:0] tb_d;
  logic       tb_oe;
  assign Data = tb_oe ? tb_d : 8'bz;
  pullup (Data);

  logic        rdy_o [NI];
  logic [15:0] wrc   [NI];

  // 0: small 16-byte RAM in $A000-$AFFF; 1: defaults; 2: $6000 window; 3: no clear at $C000
  nes_wram_mirrored #(.AW(4), .WIN_BITS(12), .BASE(16'hA000), .CLEAR_ON_RESET(1'b1), .FILL(8'hA5))
    u_small (.CLK(CLK), .n_RES(n_RES), .bus(bus), .Data(Data), .Ready(rdy_o[0]), .WrCount(wrc[0]));
  nes_wram_mirrored
    u_def   (.CLK(CLK), .n_RES(n_RES), .bus(bus), .Data(Data), .Ready(rdy_o[1]), .WrCount(wrc[1]));
  nes_wram_mirrored #(.AW(11), .WIN_BITS(13), .BASE(16'h6000), .CLEAR_ON_RESET(1'b1), .FILL(8'h5A))
    u_hi    (.CLK(CLK), .n_RES(n_RES), .bus(bus), .Data(Data), .Ready(rdy_o[2]), .WrCount(wrc[2]));
  nes_wram_mirrored #(.AW(8), .WIN_BITS(13), .BASE(16'hC000), .CLEAR_ON_RESET(1'b0), .FILL(8'h00))
    u_nc    (.CLK(CLK), .n_RES(n_RES), .bus(bus), .Data(Data), .Ready(rdy_o[3]), .WrCount(wrc[3]));

  function automatic int p_aw(input int k);
    case (k)
      0:       return 4;
      3:       return 8;
      default: return 11;
    endcase
  endfunction

  function automatic int p_win(input int k);
    return (k == 0) ? 12 : 13;
  endfunction

  function automatic logic [15:0] p_base(input int k);
    case (k)
      0:       return 16'hA000;
      1:       return 16'h0000;
      2:       return 16'h6000;
      default: return 16'hC000;
    endcase
  endfunction

  function automatic logic [7:0] p_fill(input int k);
    case (k)
      0:       return 8'hA5;
      2:       return 8'h5A;
      default: return 8'h00;
    endcase
  endfunction

  function automatic bit p_clr(input int k);
    return k != 3;
  endfunction

  // Cycles elapsed since reset release; a clearing RAM is ready after 2^AW of them.
  int since_rel;
  always @(posedge CLK or negedge n_RES) begin
    if (!n_RES) since_rel <= 0;
    else        since_rel <= since_rel + 1;
  end

  function automatic bit sel_of(input int k, input logic [15:0] a);
    return (a >> p_win(k)) == (p_base(k) >> p_win(k));
  endfunction

  function automatic int idx_of(input int k, input logic [15:0] a);
    return int'(a) % (1 << p_aw(k));
  endfunction

  function automatic bit rdy_of(input int k);
    return !p_clr(k) || (n_RES && (since_rel >= (1 << p_aw(k))));
  endfunction

  logic [7:0] mdl   [NI][2048];
  bit         known [NI][2048];
  int         mcnt  [NI];

  int vectors;
  int miscompares;
  bit chk_en;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Returns 0 when the selected cell has never been defined (no-clear RAM).
  function automatic bit exp_data(output logic [7:0] e);
    int i;
    e = 8'hFF;
    if (tb_oe) begin
      e = tb_d;
      return 1'b1;
    end
    if (bus.M2 && bus.RnW) begin
      for (int k = 0; k < NI; k++) begin
        if (sel_of(k, bus.Addr) && rdy_of(k)) begin
          i = idx_of(k, bus.Addr);
          if (!known[k][i]) return 1'b0;
          e = mdl[k][i];
          return 1'b1;
        end
      end
    end
    return 1'b1;
  endfunction

  logic [7:0] cmp_e;
  always @(negedge CLK) begin
    if (chk_en) begin
      for (int k = 0; k < NI; k++) begin
        chk($sformatf("ready%0d", k), 16'(rdy_o[k]), 16'(rdy_of(k)));
        chk($sformatf("wrcount%0d", k), wrc[k], 16'(mcnt[k]));
      end
      if (exp_data(cmp_e)) chk("data", 16'(Data), 16'(cmp_e));
    end
  end

  task automatic do_reset(input int cycles);
    @(posedge CLK); #2;
    n_RES = 1'b0;
    for (int k = 0; k < NI; k++) begin
      mcnt[k] = 0;
      if (p_clr(k)) begin
        for (int i = 0; i < (1 << p_aw(k)); i++) begin
          mdl[k][i]   = p_fill(k);
          known[k][i] = 1'b1;
        end
      end
    end
    repeat (cycles) @(posedge CLK);
    #2;
    n_RES = 1'b1;
  endtask

  // One M2-high phase of hi cycles, then M2 low; a write lands on the falling-edge commit.
  task automatic bus_cycle(input logic [15:0] a, input bit rd, input logic [7:0] wd,
                           input int hi, output logic [7:0] rdata);
    bit wr_ok [NI];
    int i;
    @(posedge CLK); #2;
    bus.Addr = a;
    bus.RnW  = rd;
    bus.M2   = 1'b1;
    tb_oe    = !rd;
    tb_d     = wd;
    #1 rdata = Data;
    repeat (hi) @(posedge CLK);
    #2;
    for (int k = 0; k < NI; k++) wr_ok[k] = !rd && sel_of(k, a) && rdy_of(k);
    bus.M2 = 1'b0;
    tb_oe  = 1'b0;
    @(posedge CLK); #1;
    for (int k = 0; k < NI; k++) begin
      if (wr_ok[k]) begin
        i = idx_of(k, a);
        mdl[k][i]   = wd;
        known[k][i] = 1'b1;
        if (mcnt[k] < 65535) mcnt[k]++;
      end
    end
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    logic [7:0] dummy;
    bus_cycle(a, 1'b0, d, 3, dummy);
  endtask

  task automatic rd(input logic [15:0] a, output logic [7:0] d);
    bus_cycle(a, 1'b1, 8'h00, 1, d);
  endtask

  task automatic ready_window(input string nm);
    repeat (15) @(posedge CLK);
    #3 chk({nm, "_ready_at15"}, 16'(rdy_o[0]), 16'h0000);
    @(posedge CLK);
    #3 chk({nm, "_ready_at16"}, 16'(rdy_o[0]), 16'h0001);
  endtask

  logic [7:0]  rv;
  logic [7:0]  hv;
  logic [15:0] ra;
  int          rk;

  initial begin
    n_RES = 1'b0;
    bus.M2 = 1'b0; bus.RnW = 1'b1; bus.Addr = 16'h4000;
    tb_oe = 1'b0; tb_d = 8'h00;
    vectors = 0; miscompares = 0; chk_en = 1'b0;
    for (int k = 0; k < NI; k++) begin
      mcnt[k] = 0;
      for (int i = 0; i < 2048; i++) known[k][i] = 1'b0;
    end
    repeat (2) @(posedge CLK);
    chk_en = 1'b1;

    do_reset(2);
    #1;
    chk("rst_small_ready", 16'(rdy_o[0]), 16'h0000);
    chk("rst_noclr_ready", 16'(rdy_o[3]), 16'h0001);
    chk("rst_def_wrcount", wrc[1], 16'h0000);
    ready_window("clear");

    // Write while the 2 KB RAMs are still clearing: dropped, not counted.
    wr(16'h6001, 8'hFF);
    chk("clr_write_cnt", wrc[2], 16'h0000);

    rd(16'hA003, rv);  chk("small_fill", 16'(rv), 16'h00A5);
    wr(16'hA012, 8'h3C);
    chk("small_wrcount", wrc[0], 16'h0001);
    rd(16'hA012, rv);  chk("small_raw", 16'(rv), 16'h003C);
    rd(16'hAFF2, rv);  chk("small_mirror", 16'(rv), 16'h003C);

    repeat (2100) @(posedge CLK);
    rd(16'h6001, rv);  chk("clr_write_dropped", 16'(rv), 16'h005A);
    chk("clr_write_cnt2", wrc[2], 16'h0000);

    // Reset mid-clear when the small RAM's clear counter reaches 7.
    do_reset(2);
    repeat (6) @(posedge CLK);
    do_reset(2);
    ready_window("reclear");
    for (int i = 0; i < 16; i++) begin
      rd(16'hA000 | 16'(i) | 16'(16 * $urandom_range(0, 255)), rv);
      chk($sformatf("reclear_cell%0d", i), 16'(rv), 16'h00A5);
    end
    chk("reclear_wrcount", wrc[0], 16'h0000);
    repeat (2100) @(posedge CLK);

    wr(16'h0005, 8'h77);
    rd(16'h0805, rv);  chk("mirror_0805", 16'(rv), 16'h0077);
    rd(16'h1005, rv);  chk("mirror_1005", 16'(rv), 16'h0077);
    rd(16'h1805, rv);  chk("mirror_1805", 16'(rv), 16'h0077);
    rd(16'h2005, rv);  chk("unsel_float", 16'(rv), 16'h00FF);

    hv = 8'($urandom_range(0, 254));
    wr(16'h6000, hv);
    rd(16'h7800, rv);  chk("base_mirror", 16'(rv), 16'(hv));
    wr(16'h4000, 8'h11);
    rd(16'h4000, rv);  chk("unmapped_float", 16'(rv), 16'h00FF);
    wr(16'h0000, 8'h22);
    rd(16'h6000, rv);  chk("base_untouched", 16'(rv), 16'(hv));
    wr(16'hC0AB, 8'h3D);
    rd(16'hDFAB, rv);  chk("noclr_mirror", 16'(rv), 16'h003D);

    for (int n = 0; n < 300; n++) begin
      rk = $urandom_range(0, 4);
      if (rk < NI) ra = p_base(rk) | 16'($urandom_range(0, (1 << p_win(rk)) - 1));
      else         ra = 16'h4000 | 16'($urandom_range(0, 16'h1FFF));
      bus_cycle(ra, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 254)),
                $urandom_range(1, 3), rv);
    end

    repeat (2) @(posedge CLK);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/nes_wram_mirrored.md
Name: nes_wram_mirrored

Overview:
- Parametrised NES work-RAM model for the APU/CPU player benches. It replaces the read-as-zero stub with real byte storage.
- Storage is decoded in a configurable window and mirrored across that window. Writes commit on M2 falling edge; reads are driven while M2 is high.
- An optional post-reset clear sequencer fills the array with a known value before the RAM reports ready.
- Sits on the APU external bus (A/D/RnW/M2) next to the APU instance; clocked by the same CLK.

Parameters:
- AW, 11, physical address bits; depth = 2^AW bytes (11 = 2 KB, as on NES).
- WIN_BITS, 13, decode window size = 2^WIN_BITS bytes; must satisfy AW <= WIN_BITS <= 16; the array mirrors 2^(WIN_BITS-AW) times.
- BASE, 16'h0000, window base; only bits [15:WIN_BITS] are compared.
- CLEAR_ON_RESET, 1, 1 = run the clear sequencer after reset; 0 = Ready immediately, contents undefined (X).
- FILL, 8'h00, byte written by the clear sequencer.

Ports:
- CLK  input  1  bench master clock; all state updates on posedge.
- n_RES  input  1  asynchronous active-low reset.
- M2  input  1  CPU M2 phase from APU.
- RnW  input  1  1 = read, 0 = write.
- Addr  input  16  CPU address bus.
- Data  inout  8  CPU data bus; driven only during selected reads, else 8'bz.
- Ready  output  1  1 = clear done, RAM accepts accesses.
- WrCount  output  16  number of committed CPU writes since reset; saturates at 16'hFFFF.

Behaviour:
- Select: sel = (Addr[15:WIN_BITS] == BASE[15:WIN_BITS]). Index idx = Addr[AW-1:0], giving the mirroring.
- Reset (n_RES=0, asynchronous):
  - state = CLEAR if CLEAR_ON_RESET else READY.
  - clear counter = 0; Ready = 0 (1 if CLEAR_ON_RESET=0).
  - WrCount = 0; m2_q = 0; Data = z. Array contents are not touched by reset itself.
- State machine, states CLEAR and READY:
  - CLEAR: each posedge writes FILL to mem[cnt] and increments cnt.
  - When cnt = 2^AW-1 is written, go to READY on that same edge. Ready = 1 from the next cycle, so the clear takes exactly 2^AW cycles after reset release.
  - READY: terminal state until the next reset.
  - Reset mid-clear restarts from cnt = 0.
- Bus sampling: m2_q <= M2 each posedge.
  - While M2 = 1, latch a_lat <= idx, d_lat <= Data, w_lat <= (sel & ~RnW) every posedge.
  - A write commits on the posedge where m2_q = 1 and M2 = 0 (falling edge detected), using the latched values: mem[a_lat] <= d_lat if w_lat and state = READY.
  - Each commit increments WrCount, saturating.
- Writes during CLEAR are dropped and not counted.
- Read: Data = mem[idx] combinationally when sel & RnW & M2 & Ready; otherwise z. There is no read latency beyond combinational lookup.
- Read-after-write: a read issued in the M2-high phase after a commit returns the new value.
- Same-address mirrors, e.g. $0005 and $0805 with AW=11: both resolve to one cell.
- Unselected addresses never write and never drive Data.

Test Plan:
- Clear: CLEAR_ON_RESET=1, AW=4, FILL=8'hA5; release reset → Ready rises after exactly 16 CLK; read $0003 returns 8'hA5.
- Write/read: write 8'h3C to $0012 (M2 high for 3 CLK, then low) → WrCount = 1; read $0012 returns 8'h3C.
- Mirror: defaults; write 8'h77 to $0005 → reads of $0805, $1005 and $1805 return 8'h77; read $2005 leaves Data = z.
- Write during CLEAR: write 8'hFF to $0001 while Ready=0 → after clear, read $0001 returns FILL and WrCount = 0.
- Reset mid-clear: assert n_RES at cnt = 7 for 2 CLK → Ready rises 2^AW CLK after the second release; all cells read FILL.
- Non-default BASE: BASE=16'h6000, WIN_BITS=13 → write to $6000 and read $7800 (mirror) return equal; access to $0000 has no effect and Data = z.
